// File: rtl/dds_phase_accumulator_pkg.sv
// Shared constants, FSM state type and state-selection helper for the DDS phase accumulator.
package dds_phase_accumulator_pkg;

    localparam int unsigned ROM_PHASE_BIT = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } dds_state_e;

    // State entered when a pending config is applied.
    function automatic dds_state_e apply_state(input logic ftw_zero, input logic sweep);
        if (ftw_zero) begin
            return ST_IDLE;
        end
        return sweep ? ST_SWEEP : ST_RUN;
    endfunction

endpackage

// File: rtl/dds_cfg_holder.sv
// Pending-config register with valid/ready handshake; issues the apply strobe at a wrap or when idle.
module dds_cfg_holder
    import dds_phase_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned PHASE_BIT = ROM_PHASE_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_carry,
    input  logic                 i_ftw_zero,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_ftw,
    input  logic [PHASE_BIT-1:0] cfg_poff,
    input  logic                 cfg_sweep,
    input  logic [ACC_WIDTH-1:0] cfg_step,
    input  logic [ACC_WIDTH-1:0] cfg_stop,
    output logic                 o_apply,
    output logic [ACC_WIDTH-1:0] o_ftw,
    output logic [PHASE_BIT-1:0] o_poff,
    output logic                 o_sweep,
    output logic [ACC_WIDTH-1:0] o_step,
    output logic [ACC_WIDTH-1:0] o_stop
);

    logic                 r_pending;
    logic [ACC_WIDTH-1:0] r_ftw;
    logic [PHASE_BIT-1:0] r_poff;
    logic                 r_sweep;
    logic [ACC_WIDTH-1:0] r_step;
    logic [ACC_WIDTH-1:0] r_stop;
    logic                 w_accept;

    assign cfg_ready = ~r_pending;
    assign w_accept  = cfg_valid & ~r_pending;
    // Capture and apply are mutually exclusive: capture needs an empty slot, apply a full one.
    assign o_apply   = r_pending & i_en & (i_carry | i_ftw_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_ftw     <= '0;
            r_poff    <= '0;
            r_sweep   <= 1'b0;
            r_step    <= '0;
            r_stop    <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_ftw     <= cfg_ftw;
            r_poff    <= cfg_poff;
            r_sweep   <= cfg_sweep;
            r_step    <= cfg_step;
            r_stop    <= cfg_stop;
        end else if (o_apply) begin
            r_pending <= 1'b0;
        end
    end

    assign o_ftw   = r_ftw;
    assign o_poff  = r_poff;
    assign o_sweep = r_sweep;
    assign o_step  = r_step;
    assign o_stop  = r_stop;

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: truncated accumulator MSBs plus offset, phase-continuous retune and linear FTW sweep.
module dds_phase_accumulator
    import dds_phase_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned PHASE_BIT = ROM_PHASE_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_ftw,
    input  logic [PHASE_BIT-1:0] cfg_poff,
    input  logic                 cfg_sweep,
    input  logic [ACC_WIDTH-1:0] cfg_step,
    input  logic [ACC_WIDTH-1:0] cfg_stop,
    output logic [PHASE_BIT-1:0] phase,
    output logic                 wrap,
    output logic                 sweep_done
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_ftw;
    logic [PHASE_BIT-1:0] r_poff;
    logic [ACC_WIDTH-1:0] r_step;
    logic [ACC_WIDTH-1:0] r_stop;
    logic [PHASE_BIT-1:0] r_phase;
    logic                 r_wrap;
    logic                 r_sweep_done;
    dds_state_e           r_state;

    logic [ACC_WIDTH:0]   w_acc_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_carry;
    logic [PHASE_BIT-1:0] w_phase_next;
    logic [ACC_WIDTH:0]   w_sweep_sum;
    logic                 w_sweep_hit;
    logic                 w_ftw_zero;
    logic                 w_apply;
    logic [ACC_WIDTH-1:0] w_pend_ftw;
    logic [PHASE_BIT-1:0] w_pend_poff;
    logic                 w_pend_sweep;
    logic [ACC_WIDTH-1:0] w_pend_step;
    logic [ACC_WIDTH-1:0] w_pend_stop;

    dds_cfg_holder #(
        .ACC_WIDTH (ACC_WIDTH),
        .PHASE_BIT (PHASE_BIT)
    ) u_cfg_holder (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_carry    (w_carry),
        .i_ftw_zero (w_ftw_zero),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ftw    (cfg_ftw),
        .cfg_poff   (cfg_poff),
        .cfg_sweep  (cfg_sweep),
        .cfg_step   (cfg_step),
        .cfg_stop   (cfg_stop),
        .o_apply    (w_apply),
        .o_ftw      (w_pend_ftw),
        .o_poff     (w_pend_poff),
        .o_sweep    (w_pend_sweep),
        .o_step     (w_pend_step),
        .o_stop     (w_pend_stop)
    );

    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
    assign w_carry      = w_acc_sum[ACC_WIDTH];
    assign w_acc_next   = w_acc_sum[ACC_WIDTH-1:0];
    assign w_phase_next = w_acc_next[ACC_WIDTH-1 -: PHASE_BIT] + r_poff;
    assign w_ftw_zero   = (r_ftw == '0);

    // Extra bit keeps ftw+step from wrapping before the clamp to stop.
    assign w_sweep_sum  = {1'b0, r_ftw} + {1'b0, r_step};
    assign w_sweep_hit  = (w_sweep_sum >= {1'b0, r_stop});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_ftw        <= '0;
            r_poff       <= '0;
            r_step       <= '0;
            r_stop       <= '0;
            r_phase      <= '0;
            r_wrap       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_state      <= ST_IDLE;
        end else if (en) begin
            r_acc        <= w_acc_next;
            r_phase      <= w_phase_next;
            r_wrap       <= w_carry;
            r_sweep_done <= 1'b0;
            // New config takes over from the next add; an apply on a wrap suppresses the sweep step.
            if (w_apply) begin
                r_ftw   <= w_pend_ftw;
                r_poff  <= w_pend_poff;
                r_step  <= w_pend_step;
                r_stop  <= w_pend_stop;
                r_state <= apply_state(w_pend_ftw == '0, w_pend_sweep);
            end else if (r_state == ST_SWEEP && w_carry) begin
                if (w_sweep_hit) begin
                    r_ftw        <= r_stop;
                    r_sweep_done <= 1'b1;
                    r_state      <= ST_RUN;
                end else begin
                    r_ftw <= w_sweep_sum[ACC_WIDTH-1:0];
                end
            end
        end else begin
            r_wrap       <= 1'b0;
            r_sweep_done <= 1'b0;
        end
    end

    assign phase      = r_phase;
    assign wrap       = r_wrap;
    assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Self-checking bench for dds_phase_accumulator against a queue-based arithmetic reference model.
module tb_dds_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_ftw = '0;
    logic [9:0]  cfg_poff = '0;
    logic        cfg_sweep = 1'b0;
    logic [31:0] cfg_step = '0;
    logic [31:0] cfg_stop = '0;
    logic [9:0]  phase;
    logic        wrap;
    logic        sweep_done;

    int unsigned checks = 0;
    int unsigned failures = 0;

    dds_phase_accumulator #(
        .ACC_WIDTH (32),
        .PHASE_BIT (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ftw    (cfg_ftw),
        .cfg_poff   (cfg_poff),
        .cfg_sweep  (cfg_sweep),
        .cfg_step   (cfg_step),
        .cfg_stop   (cfg_stop),
        .phase      (phase),
        .wrap       (wrap),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] ftw;
        bit [9:0]  poff;
        bit        sweep;
        bit [31:0] step;
        bit [31:0] stop;
    } cfg_t;

    // Reference model state: what the spec says the block holds, in plain arithmetic.
    cfg_t      pq[$];
    bit [31:0] m_acc, m_ftw, m_step, m_stop;
    bit [9:0]  m_poff, m_phase;
    bit        m_sweeping, m_wrap, m_done;
    bit        m_ready = 1'b1;

    task automatic model_step();
        bit              accept;
        bit              carry;
        longint unsigned s;
        longint unsigned nf;
        cfg_t            c;
        if (rst) begin
            m_acc = 0; m_ftw = 0; m_step = 0; m_stop = 0; m_poff = 0;
            m_phase = 0; m_wrap = 0; m_done = 0; m_sweeping = 0;
            pq.delete();
            m_ready = 1;
            return;
        end
        accept = cfg_valid && (pq.size() == 0);
        m_done = 0;
        if (en) begin
            s = 64'(m_acc) + 64'(m_ftw);
            carry = (s >= 64'h1_0000_0000);
            s = s % 64'h1_0000_0000;
            m_phase = 10'((s / 64'h40_0000) + 64'(m_poff));
            m_acc = 32'(s);
            m_wrap = carry;
            if (pq.size() > 0 && (carry || m_ftw == 0)) begin
                c = pq.pop_front();
                m_ftw = c.ftw; m_poff = c.poff; m_step = c.step; m_stop = c.stop;
                m_sweeping = c.sweep && (c.ftw != 0);
            end else if (m_sweeping && carry) begin
                nf = 64'(m_ftw) + 64'(m_step);
                if (nf >= 64'(m_stop)) begin
                    nf = 64'(m_stop);
                    m_sweeping = 0;
                    m_done = 1;
                end
                m_ftw = 32'(nf);
            end
        end else begin
            m_wrap = 0;
        end
        if (accept) pq.push_back('{cfg_ftw, cfg_poff, cfg_sweep, cfg_step, cfg_stop});
        m_ready = (pq.size() == 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [31:0] ftw, input logic [9:0] poff, input logic sw,
                            input logic [31:0] step, input logic [31:0] stop);
        int unsigned n = 0;
        while (!m_ready && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 5000 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_wait: cfg_ready=%b after %0d clk, required 1 within 5000", cfg_ready, n);
        end
        cfg_ftw = ftw; cfg_poff = poff; cfg_sweep = sw; cfg_step = step; cfg_stop = stop;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b1;
        cfg_ftw = 32'h0040_0000; cfg_poff = '0; cfg_sweep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({phase, wrap, sweep_done, cfg_ready} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_hold: phase=%0d wrap=%b done=%b rdy=%b, required 0 0 0 1",
                         phase, wrap, sweep_done, cfg_ready);
            end
        end
        rst = 1'b0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_accept: cfg_ready=%b, required 0", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b1 || phase !== 10'd0) begin
            failures++;
            $display("FAIL reset_apply_now: rdy=%b phase=%0d, required 1 0", cfg_ready, phase);
        end
        tick();
        checks++;
        if (phase !== 10'd1) begin
            failures++;
            $display("FAIL reset_first_step: phase=%0d, required 1", phase);
        end
    endtask

    task automatic test_fixed_tone();
        logic [9:0] prev;
        int         last_wrap = -1;
        prev = phase;
        for (int i = 0; i < 2100; i++) begin
            tick();
            checks++;
            if ({phase, wrap, sweep_done, cfg_ready} !== {m_phase, m_wrap, m_done, m_ready}) begin
                failures++;
                $display("FAIL fixed_model: cyc=%0d got %0d/%b/%b/%b, required %0d/%b/%b/%b",
                         i, phase, wrap, sweep_done, cfg_ready, m_phase, m_wrap, m_done, m_ready);
            end
            checks++;
            if (phase !== prev + 10'd1 || wrap !== (phase == 10'd0)) begin
                failures++;
                $display("FAIL fixed_step: cyc=%0d phase=%0d wrap=%b, required %0d %b",
                         i, phase, wrap, prev + 10'd1, (prev + 10'd1) == 10'd0);
            end
            if (wrap === 1'b1) begin
                if (last_wrap >= 0) begin
                    checks++;
                    if (i - last_wrap != 1024) begin
                        failures++;
                        $display("FAIL fixed_period: %0d clk between wraps, required 1024", i - last_wrap);
                    end
                end
                last_wrap = i;
            end
            prev = phase;
        end
    endtask

    task automatic test_retune();
        logic [9:0]  prev;
        int unsigned n = 0;
        bit          seen = 0;
        load_cfg(32'h0100_0000, 10'd0, 1'b0, '0, '0);
        while (!(m_ftw == 32'h0100_0000 && m_wrap) && n < 3000) begin
            tick();
            n++;
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({phase, wrap, cfg_ready} !== {m_phase, m_wrap, m_ready}) begin
                failures++;
                $display("FAIL retune_model: cyc=%0d got %0d/%b/%b, required %0d/%b/%b",
                         i, phase, wrap, cfg_ready, m_phase, m_wrap, m_ready);
            end
        end
        load_cfg(32'h0200_0000, 10'd0, 1'b0, '0, '0);
        prev = phase;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            checks++;
            if (wrap === 1'b1) begin
                seen = 1;
                if (phase - prev !== 10'd4 || cfg_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL retune_wrap: delta=%0d rdy=%b, required 4 1", phase - prev, cfg_ready);
                end
            end else if (cfg_ready !== 1'b0 || phase - prev !== 10'd4) begin
                failures++;
                $display("FAIL retune_pending: rdy=%b delta=%0d, required 0 4", cfg_ready, phase - prev);
            end
            prev = phase;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL retune_timeout: wrap=0 for 300 clk, required a wrap");
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (phase - prev !== 10'd8) begin
                failures++;
                $display("FAIL retune_new_step: delta=%0d, required 8", phase - prev);
            end
            prev = phase;
        end
    endtask

    task automatic test_offset();
        logic [9:0] held;
        load_cfg(32'h0040_0000, 10'd256, 1'b0, '0, '0);
        for (int i = 0; i < 1300; i++) begin
            tick();
            checks++;
            if ({phase, wrap, cfg_ready} !== {m_phase, m_wrap, m_ready}) begin
                failures++;
                $display("FAIL offset_model: cyc=%0d got %0d/%b/%b, required %0d/%b/%b",
                         i, phase, wrap, cfg_ready, m_phase, m_wrap, m_ready);
            end
        end
        checks++;
        if (phase !== 10'((m_acc >> 22) + 256)) begin
            failures++;
            $display("FAIL offset_value: phase=%0d, required %0d", phase, 10'((m_acc >> 22) + 256));
        end
        held = phase;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (phase !== held || wrap !== 1'b0) begin
                failures++;
                $display("FAIL offset_freeze: phase=%0d wrap=%b, required %0d 0", phase, wrap, held);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (phase !== held + 10'd1) begin
            failures++;
            $display("FAIL offset_resume: phase=%0d, required %0d", phase, held + 10'd1);
        end
    endtask

    task automatic test_sweep();
        logic [9:0] prev;
        int         dones = 0;
        int         after = 0;
        load_cfg(32'h0040_0000, 10'd0, 1'b1, 32'h0040_0000, 32'h00C0_0000);
        prev = phase;
        for (int i = 0; i < 4000 && after < 6; i++) begin
            tick();
            checks++;
            if ({phase, wrap, sweep_done, cfg_ready} !== {m_phase, m_wrap, m_done, m_ready}) begin
                failures++;
                $display("FAIL sweep_model: cyc=%0d got %0d/%b/%b/%b, required %0d/%b/%b/%b",
                         i, phase, wrap, sweep_done, cfg_ready, m_phase, m_wrap, m_done, m_ready);
            end
            if (sweep_done === 1'b1) begin
                dones++;
                checks++;
                if (wrap !== 1'b1) begin
                    failures++;
                    $display("FAIL sweep_done_wrap: wrap=%b with sweep_done, required 1", wrap);
                end
            end else if (dones > 0) begin
                after++;
                checks++;
                if (phase - prev !== 10'd3) begin
                    failures++;
                    $display("FAIL sweep_hold: delta=%0d, required 3", phase - prev);
                end
            end
            prev = phase;
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL sweep_done_count: %0d pulses, required 1", dones);
        end
    endtask

    task automatic test_overflow();
        int unsigned n = 0;
        load_cfg(32'hFFFF_FFFF, 10'd0, 1'b0, '0, '0);
        while (m_ftw != 32'hFFFF_FFFF && n < 3000) begin
            tick();
            n++;
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (wrap !== 1'b1 || phase !== m_phase) begin
                failures++;
                $display("FAIL overflow: cyc=%0d wrap=%b phase=%0d, required 1 %0d", i, wrap, phase, m_phase);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int unsigned n = 0;
        load_cfg(32'h0040_0000, 10'd5, 1'b1, 32'h0010_0000, 32'h0100_0000);
        while (!m_sweeping && n < 3000) begin
            tick();
            n++;
        end
        for (int i = 0; i < 600; i++) tick();
        load_cfg(32'h1234_5678, 10'd77, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({phase, wrap, sweep_done, cfg_ready} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_sweep: phase=%0d wrap=%b done=%b rdy=%b, required 0 0 0 1",
                     phase, wrap, sweep_done, cfg_ready);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({phase, wrap, sweep_done, cfg_ready} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_discard: cyc=%0d phase=%0d wrap=%b rdy=%b, required 0 0 1",
                         i, phase, wrap, cfg_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if (m_ready && $urandom_range(0, 3) == 0) begin
                f = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> 1);
                cfg_ftw = f;
                cfg_poff = 10'($urandom);
                cfg_sweep = $urandom_range(0, 1) == 1;
                cfg_step = $urandom_range(1, 32'h1000_0000);
                cfg_stop = f + ($urandom >> 2);
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
            checks++;
            if ({phase, wrap, sweep_done, cfg_ready} !== {m_phase, m_wrap, m_done, m_ready}) begin
                failures++;
                $display("FAIL random_model: cyc=%0d got %0d/%b/%b/%b, required %0d/%b/%b/%b",
                         i, phase, wrap, sweep_done, cfg_ready, m_phase, m_wrap, m_done, m_ready);
            end
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fixed_tone();
        test_retune();
        test_offset();
        test_sweep();
        test_overflow();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
